// File: rtl/cache_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_ram_pkg
// Brief    : Shared types and constants for the cache-to-RAM bridge.
// Revision : 1.0
// ============================================================================
package cache_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_LAST = 2'd2,
        ST_WR      = 2'd3
    } state_t;

    localparam logic [2:0] TYPE_LINE  = 3'b100;
    localparam int         LINE_BEATS = 4;
    localparam logic [1:0] LAST_BEAT  = 2'(LINE_BEATS - 1);

    function automatic logic [31:0] word_sel(input logic [127:0] data, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = data[31:0];
            2'd1:    w = data[63:32];
            2'd2:    w = data[95:64];
            default: w = data[127:96];
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : cache_wbuf
// Brief    : One-entry write buffer; reports a same-line match against a read.
// Revision : 1.0
// ============================================================================
module cache_wbuf
    import cache_ram_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    input  logic         clear,
    input  logic [27:0]  cmp_line,
    output logic         wr_rdy,
    output logic         valid,
    output logic [31:0]  addr,
    output logic         is_line,
    output logic [3:0]   wstrb,
    output logic [127:0] data,
    output logic         line_match
);

    logic         r_valid;
    logic [31:0]  r_addr;
    logic         r_line;
    logic [3:0]   r_wstrb;
    logic [127:0] r_data;

    // Accept and clear never coincide: accept needs empty, clear needs full.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_line  <= 1'b0;
            r_wstrb <= '0;
            r_data  <= '0;
        end else if (wr_req && !r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= wr_addr;
            r_line  <= (wr_type == TYPE_LINE);
            r_wstrb <= wr_wstrb;
            r_data  <= wr_data;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign wr_rdy     = !r_valid;
    assign valid      = r_valid;
    assign addr       = r_addr;
    assign is_line    = r_line;
    assign wstrb      = r_wstrb;
    assign data       = r_data;
    assign line_match = r_valid && (cmp_line == r_addr[31:4]);

endmodule
`default_nettype wire

// File: rtl/cache_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cache_ram_bridge
// Brief    : Sequences cache read/write requests into beats on a 1-cycle RAM.
//            Optional macro: CACHE_BRIDGE_RAW_CHECK_EN (block reads on same line only).
// Revision : 1.0
// ============================================================================
module cache_ram_bridge
    import cache_ram_pkg::*;
#(
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_line;
    logic [RAM_AW-1:0]   r_base;

    logic                w_buf_valid;
    logic [31:0]         w_buf_addr;
    logic                w_buf_line;
    logic [3:0]          w_buf_wstrb;
    logic [127:0]        w_buf_data;
    logic                w_line_match;
    logic                w_rd_block;
    logic                w_rd_accept;
    logic                w_rd_line;
    logic                w_last;
    logic                w_wr_clear;
    logic [RAM_AW-1:0]   w_rd_waddr;
    logic [RAM_AW-1:0]   w_buf_waddr;
    logic                w_unused_ok;

    cache_wbuf u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .wr_req     (wr_req),
        .wr_type    (wr_type),
        .wr_addr    (wr_addr),
        .wr_wstrb   (wr_wstrb),
        .wr_data    (wr_data),
        .clear      (w_wr_clear),
        .cmp_line   (rd_addr[31:4]),
        .wr_rdy     (wr_rdy),
        .valid      (w_buf_valid),
        .addr       (w_buf_addr),
        .is_line    (w_buf_line),
        .wstrb      (w_buf_wstrb),
        .data       (w_buf_data),
        .line_match (w_line_match)
    );

`ifdef CACHE_BRIDGE_RAW_CHECK_EN
    assign w_rd_block = w_buf_valid && w_line_match;
`else
    assign w_rd_block = w_buf_valid;
`endif

    // Address bits above the RAM and below the word are intentionally ignored.
    assign w_unused_ok = ^{rd_addr, w_buf_addr, w_line_match};

    assign w_rd_waddr  = rd_addr[RAM_AW+1:2];
    assign w_buf_waddr = w_buf_addr[RAM_AW+1:2];
    assign w_rd_line   = (rd_type == TYPE_LINE);
    assign rd_rdy      = (r_state == ST_IDLE) && !w_rd_block;
    assign w_rd_accept = rd_req && rd_rdy;
    assign w_last      = r_line ? (r_cnt == LAST_BEAT) : 1'b1;
    assign w_wr_clear  = (r_state == ST_WR) && w_last;
    assign ret_data    = ret_valid ? mem_rdata : 32'h0;

    // mem_* always describe the beat issued in the current cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_line    <= 1'b0;
            r_base    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
        end else begin
            ret_valid <= (r_state == ST_RD);
            ret_last  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_accept) begin
                        r_state  <= ST_RD;
                        r_cnt    <= '0;
                        r_line   <= w_rd_line;
                        r_base   <= w_rd_line ? {w_rd_waddr[RAM_AW-1:2], 2'b00} : w_rd_waddr;
                        mem_en   <= 1'b1;
                        mem_addr <= w_rd_line ? {w_rd_waddr[RAM_AW-1:2], 2'b00} : w_rd_waddr;
                    end else if (w_buf_valid) begin
                        r_state   <= ST_WR;
                        r_cnt     <= '0;
                        r_line    <= w_buf_line;
                        mem_en    <= 1'b1;
                        mem_we    <= w_buf_line ? 4'hF : w_buf_wstrb;
                        mem_addr  <= w_buf_line ? {w_buf_waddr[RAM_AW-1:2], 2'b00} : w_buf_waddr;
                        mem_wdata <= word_sel(w_buf_data, 2'd0);
                    end
                end
                ST_RD: begin
                    if (w_last) begin
                        r_state  <= ST_RD_LAST;
                        ret_last <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 2'd1;
                        mem_en   <= 1'b1;
                        mem_addr <= {r_base[RAM_AW-1:2], r_cnt + 2'd1};
                    end
                end
                ST_RD_LAST: begin
                    r_state <= ST_IDLE;
                end
                ST_WR: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt     <= r_cnt + 2'd1;
                        mem_en    <= 1'b1;
                        mem_we    <= 4'hF;
                        mem_addr  <= {w_buf_waddr[RAM_AW-1:2], r_cnt + 2'd1};
                        mem_wdata <= word_sel(w_buf_data, r_cnt + 2'd1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ram_bridge
// Brief    : Directed + randomized self-checking bench against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_cache_ram_bridge;

    localparam int RAM_AW = 8;
    localparam int DEPTH  = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rd_req = 1'b0;
    logic [2:0]        rd_type = 3'b0;
    logic [31:0]       rd_addr = 32'h0;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              wr_req = 1'b0;
    logic [2:0]        wr_type = 3'b0;
    logic [31:0]       wr_addr = 32'h0;
    logic [3:0]        wr_wstrb = 4'h0;
    logic [127:0]      wr_data = '0;
    logic              wr_rdy;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [RAM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        ram_load = 1'b1;

    int checks = 0;
    int errors = 0;

    bit           ovl_en = 1'b0;
    logic [31:0]  ovl_addr = 32'h0;
    logic [127:0] ovl_data = '0;

    cache_ram_bridge #(.RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
        end else if (mem_en) begin
            if (mem_we == 4'h0) mem_rdata <= ram[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] single_type();
        int t;
        t = $urandom_range(0, 6);
        if (t >= 4) t++;
        return 3'(t);
    endfunction

    // Cache-visible memory contents after an accepted write.
    function automatic void ref_write(input logic [31:0] a, input logic [2:0] t,
                                      input logic [3:0] s, input logic [127:0] d);
        int w;
        w = int'(a[RAM_AW+1:2]);
        if (t == 3'b100) begin
            for (int i = 0; i < 4; i++) ref_mem[(w & ~3) + i] = d[32*i +: 32];
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!(rd_rdy && wr_rdy) && k < 40) begin tick(); k++; end
        chk({tag, "_idle_wait"}, rd_rdy && wr_rdy, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                            input logic [127:0] d, input string tag);
        int k;
        k = 0;
        wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d; wr_req = 1'b1;
        while (!wr_rdy && k < 40) begin tick(); k++; end
        chk({tag, "_wr_rdy_wait"}, wr_rdy, 1'b1);
        ref_write(a, t, s, d);
        tick();
        wr_req = 1'b0;
    endtask

    // Returns in the cycle after the final return beat.
    task automatic do_read(input logic [31:0] a, input bit line, input string tag);
        logic [31:0]       exp_w [4];
        logic [RAM_AW-1:0] wa;
        logic [RAM_AW-1:0] first;
        int n, k;
        n     = line ? 4 : 1;
        wa    = a[RAM_AW+1:2];
        first = line ? {wa[RAM_AW-1:2], 2'b00} : wa;
        rd_addr = a; rd_type = line ? 3'b100 : single_type(); rd_req = 1'b1;
        k = 0;
        while (!rd_rdy && k < 40) begin tick(); k++; end
        chk({tag, "_rd_rdy_wait"}, rd_rdy, 1'b1);
        for (int i = 0; i < n; i++) exp_w[i] = ref_mem[int'(first) + i];
        tick();
        rd_req = 1'b0;
        if (ovl_en) begin
            wr_addr = ovl_addr; wr_type = 3'b100; wr_wstrb = 4'h0; wr_data = ovl_data; wr_req = 1'b1;
            chk({tag, "_ovl_wr_rdy"}, wr_rdy, 1'b1);
            ref_write(ovl_addr, 3'b100, 4'h0, ovl_data);
        end
        chk({tag, "_beat0_en"}, mem_en, 1'b1);
        chk({tag, "_beat0_we"}, mem_we, 4'h0);
        chk({tag, "_beat0_addr"}, mem_addr, first);
        chk({tag, "_ret_early"}, ret_valid, 1'b0);
        for (int b = 0; b < n; b++) begin
            tick();
            wr_req = 1'b0;
            chk({tag, "_ret_valid"}, ret_valid, 1'b1);
            chk({tag, "_ret_last"}, ret_last, (b == n - 1));
            chk({tag, "_ret_data"}, ret_data, exp_w[b]);
        end
        tick();
        chk({tag, "_ret_end_valid"}, ret_valid, 1'b0);
        chk({tag, "_ret_end_last"}, ret_last, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [31:0]  a;
        bit           seen;
        int           k, op;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) ref_mem[16 + i] = 32'hA0 + i;
        ref_mem[2] = 32'hFFFF_FFFF;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        ram_load = 1'b0;
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_ret_valid", ret_valid, 1'b0);
        resetn = 1'b1;
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
        chk("rst_ret_last", ret_last, 1'b0);
        chk("rst_ret_data", ret_data, 32'h0);
        chk("rst_mem_we", mem_we, 4'h0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        tick();

        // Line read of 0x40: A0..A3 in order, ret_last only on the final beat
        do_read(32'h0000_0040, 1'b1, "line_rd40");
        chk("line_rd40_rd_rdy_back", rd_rdy, 1'b1);

        // Single write with partial strobes, then read-back
        do_write(32'h0000_0008, 3'b000, 4'b0011, {96'h0, 32'h1234_5678}, "sw8");
        chk("sw8_decide_no_beat", mem_en, 1'b0);
        tick();
        chk("sw8_beat_en", mem_en, 1'b1);
        chk("sw8_beat_we", mem_we, 4'b0011);
        chk("sw8_beat_addr", mem_addr, 8'd2);
        chk("sw8_beat_wdata", mem_wdata, 32'h1234_5678);
        chk("sw8_busy", wr_rdy, 1'b0);
        tick();
        chk("sw8_wr_rdy_back", wr_rdy, 1'b1);
        chk("sw8_after_we", mem_we, 4'h0);
        chk("sw8_after_wdata", mem_wdata, 32'h0);
        do_read(32'h0000_0008, 1'b0, "sw8_rb");

        // Line write then same-line read the next cycle
        d = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        do_write(32'h0000_0100, 3'b100, 4'h0, d, "lw100");
        do_read(32'h0000_0104, 1'b0, "lw100_rd104");

        // Pending write to 0x200, read to a different line 0x300
        wait_idle("raw");
        do_write(32'h0000_0200, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom}, "lw200");
        rd_addr = 32'h0000_0300; rd_type = 3'b000; rd_req = 1'b1;
`ifdef CACHE_BRIDGE_RAW_CHECK_EN
        chk("raw_bypass_rd_rdy", rd_rdy, 1'b1);
`else
        chk("raw_block_rd_rdy", rd_rdy, 1'b0);
        k = 0;
        while (!rd_rdy && k < 40) begin tick(); k++; end
        chk("raw_block_wr_drained", wr_rdy, 1'b1);
`endif
        do_read(32'h0000_0300, 1'b0, "rd300");

        // Write offered during a line read drains after ret_last plus one IDLE cycle
        wait_idle("ovl");
        ovl_en = 1'b1; ovl_addr = 32'h0000_0180;
        ovl_data = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
        do_read(32'h0000_0040, 1'b1, "ovl_rd40");
        ovl_en = 1'b0;
        chk("ovl_decide_no_beat", mem_en, 1'b0);
        tick();
        chk("ovl_beat0_en", mem_en, 1'b1);
        chk("ovl_beat0_we", mem_we, 4'hF);
        chk("ovl_beat0_addr", mem_addr, 8'h60);
        chk("ovl_beat0_wdata", mem_wdata, 32'hD0D0_D0D0);
        repeat (3) tick();
        chk("ovl_beat3_addr", mem_addr, 8'h63);
        chk("ovl_beat3_wdata", mem_wdata, 32'hD3D3_D3D3);
        chk("ovl_beat3_busy", wr_rdy, 1'b0);
        tick();
        chk("ovl_wr_rdy_back", wr_rdy, 1'b1);
        chk("ovl_done_en", mem_en, 1'b0);
        do_read(32'h0000_0184, 1'b0, "ovl_rb");

        // Upper address bits are ignored
        do_read(32'hABCD_0040, 1'b1, "alias_rd");

        // Asynchronous reset in the middle of a line read with a write buffered
        wait_idle("arst");
        rd_addr = 32'h0000_0080; rd_type = 3'b100; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_addr = 32'h0000_0008; wr_type = 3'b000; wr_wstrb = 4'hF;
        wr_data = {96'h0, 32'hDEAD_BEEF}; wr_req = 1'b1;
        chk("arst_wr_rdy", wr_rdy, 1'b1);
        tick();
        wr_req = 1'b0;
        tick();
        chk("arst_pre_valid", ret_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("arst_ret_valid", ret_valid, 1'b0);
        chk("arst_ret_last", ret_last, 1'b0);
        chk("arst_ret_data", ret_data, 32'h0);
        chk("arst_mem_en", mem_en, 1'b0);
        chk("arst_mem_we", mem_we, 4'h0);
        chk("arst_mem_addr", mem_addr, '0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("arst_rel_rd_rdy", rd_rdy, 1'b1);
        chk("arst_rel_wr_rdy", wr_rdy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ret_valid || ret_last || mem_en) seen = 1'b1;
        end
        chk("arst_quiet", seen, 1'b0);
        do_read(32'h0000_0008, 1'b0, "arst_discard_rb");

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 1023));
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (op == 0) begin
                do_read(a, 1'($urandom_range(0, 1)), "rnd_rd");
            end else if (op == 1) begin
                if ($urandom_range(0, 1) == 1) do_write(a, 3'b100, 4'($urandom), d, "rnd_lw");
                else do_write(a, single_type(), 4'($urandom), d, "rnd_sw");
            end else begin
                if ($urandom_range(0, 1) == 1) do_write(a, 3'b100, 4'($urandom), d, "rnd_raw_lw");
                else do_write(a, single_type(), 4'($urandom), d, "rnd_raw_sw");
                do_read({a[31:4], 4'($urandom)}, 1'($urandom_range(0, 1)), "rnd_raw_rd");
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
